// File: rtl/fix_point_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (divider, multiplier).
package fix_point_pkg;

  localparam int Q_DEF = 12;
  localparam int N_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // Saturation codes: largest positive and most negative symmetric value.
  localparam logic [N_DEF-1:0] SAT_POS = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] SAT_NEG = {1'b1, {(N_DEF-2){1'b0}}, 1'b1};

endpackage

// File: rtl/fix_point_abs.sv
// Sign/magnitude split of a two's complement word. The most negative value
// has no positive counterpart, so its magnitude clamps to all ones.
module fix_point_abs
  import fix_point_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] val,
  output logic         neg,
  output logic [N-2:0] mag
);

  // Negate the low bits only; the dropped sign bit is always zero after negation
  always_comb begin
    neg = val[N-1];
    if (val == {1'b1, {(N-1){1'b0}}}) begin
      mag = '1;
    end else if (val[N-1]) begin
      mag = (~val[N-2:0]) + {{(N-2){1'b0}}, 1'b1};
    end else begin
      mag = val[N-2:0];
    end
  end

endmodule

// File: rtl/div_fix_point.sv
// Signed fixed-point divider, out = in_1 / in_2, one quotient bit per clock.
// Restoring division of (|in_1| << Q) by |in_2|, truncating toward zero,
// with saturation and divide-by-zero reporting.
module div_fix_point
  import fix_point_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] in_1,
  input  logic [N-1:0] in_2,
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int AW = N - 1 + Q;          // dividend / quotient width
  localparam int CW = $clog2(AW + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(AW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;            // dividend bits shift out, quotient bits shift in
  logic [N-2:0]  rem_q, rem_d;
  logic [N-2:0]  dvs_q, dvs_d;
  logic          rneg_q, rneg_d;          // sign of the result
  logic          aneg_q, aneg_d;          // sign of the dividend, for /0 saturation
  logic          zero_q, zero_d;
  logic [N-1:0]  out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic         a_neg, b_neg;
  logic [N-2:0] a_mag, b_mag;
  logic         accept;
  logic [N-1:0] rem_shift;
  logic         fits;
  logic         sat;
  logic [N-2:0] mag_fin;

  fix_point_abs #(.N(N)) u_abs_a (.val(in_1), .neg(a_neg), .mag(a_mag));
  fix_point_abs #(.N(N)) u_abs_b (.val(in_2), .neg(b_neg), .mag(b_mag));

  // busy also covers the done cycle, so it blocks a start there as well
  assign accept = (state_q == IDLE) && start && !busy_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; FINISH waits until the counter drains so that the
  // divide-by-zero path (counter loaded with 1) lands on a fixed latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (in_2 == '0) ? FINISH : CALC;
      CALC:    if (cnt_q == CNT_ONE) state_d = FINISH;
      FINISH:  if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output stage: operand capture, restoring step, result resolution
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    rneg_d  = rneg_q;
    aneg_d  = aneg_q;
    zero_d  = zero_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    rem_shift = {rem_q, acc_q[AW-1]};
    fits      = (rem_shift >= {1'b0, dvs_q});
    sat       = |acc_q[AW-1:N-1];
    mag_fin   = sat ? '1 : acc_q[N-2:0];

    case (state_q)
      IDLE: begin
        if (done_q) busy_d = 1'b0;
        if (accept) begin
          acc_d  = {a_mag, {Q{1'b0}}};
          rem_d  = '0;
          dvs_d  = b_mag;
          rneg_d = a_neg ^ b_neg;
          aneg_d = a_neg;
          zero_d = (in_2 == '0);
          cnt_d  = (in_2 == '0) ? CNT_ONE : CNT_LOAD;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      CALC: begin
        rem_d = fits ? (rem_shift[N-2:0] - dvs_q) : rem_shift[N-2:0];
        acc_d = {acc_q[AW-2:0], fits};
        cnt_d = cnt_q - CNT_ONE;
      end
      FINISH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          done_d = 1'b1;
          if (zero_q) begin
            dbz_d = 1'b1;
            out_d = aneg_q ? SAT_NEG : SAT_POS;
          end else begin
            ovf_d = sat;
            out_d = rneg_q ? -{1'b0, mag_fin} : {1'b0, mag_fin};
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      rneg_q <= 1'b0;
      aneg_q <= 1'b0;
      zero_q <= 1'b0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      rneg_q <= rneg_d;
      aneg_q <= aneg_d;
      zero_q <= zero_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out         = out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_fix_point.sv
// Scoreboard bench for div_fix_point: the driver pushes expected results from
// an arithmetic reference model, a monitor pops and compares on each done.
module tb_div_fix_point;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_1 = '0;
  logic [31:0] in_2 = '0;
  logic [31:0] out;
  logic        busy, done, div_by_zero, overflow;

  div_fix_point #(.Q(12), .N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_1(in_1), .in_2(in_2),
    .out(out), .busy(busy), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int txn_id = 0;

  typedef struct {
    logic [31:0] res;
    bit          dbz;
    bit          ovf;
    int          sc;
    int          lat;
    int          id;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic longint magn(input logic [31:0] x);
    logic [31:0] t;
    if (x == 32'h8000_0000) return 64'd2147483647;
    t = x[31] ? -x : x;
    return longint'(t);
  endfunction

  // Reference: exact integer division of the scaled magnitudes
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int sc);
    exp_t e;
    longint m1, m2, qv;
    m1 = magn(a);
    m2 = magn(b);
    e.sc = sc; e.a = a; e.b = b; e.id = 0;
    if (m2 == 0) begin
      e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 2;
      e.res = a[31] ? 32'h8000_0001 : 32'h7FFF_FFFF;
    end else begin
      e.dbz = 1'b0; e.lat = 44;
      qv = (m1 * 4096) / m2;
      e.ovf = (qv > 64'd2147483647);
      if (e.ovf) qv = 64'd2147483647;
      e.res = (a[31] ^ b[31]) ? 32'(-qv) : 32'(qv);
    end
    return e;
  endfunction

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Waits (bounded) for the divider to be idle, then issues one operation
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    exp_t e;
    while ((busy || done) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
      summary_and_finish();
    end
    e = model(a, b, cyc);
    e.id = txn_id++;
    sb.push_back(e);
    in_1 = a; in_2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=done required=no_done out=%h", out);
      end else begin
        e = sb.pop_front();
        check("out", out, e.res);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("busy_at_done", {31'd0, busy}, 32'd1);
        check("latency", 32'(cyc - e.sc - 1), 32'(e.lat));
        $display("txn %0d: %h / %h -> out=%h dbz=%0b ovf=%0b lat=%0d (exp %h)",
                 e.id, e.a, e.b, out, div_by_zero, overflow, cyc - e.sc - 1, e.res);
      end
    end
  end

  initial begin
    int g;
    logic [31:0] ra, rb;
    exp_t e;

    repeat (3) @(negedge clk);
    check("reset_out", out, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(32'h0000_6000, 32'h0000_2000);
    issue(32'hFFFF_D000, 32'h0000_2000);
    issue(32'h0000_1000, 32'h0000_3000);
    issue(32'hFFFF_B000, 32'h0000_0000);
    issue(32'h7FFF_FFFF, 32'h0000_0001);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 32'h7FFF_FFFF);
    issue(32'h0000_0000, 32'hFFFF_F000);
    issue(32'h0000_1000, 32'h0000_0000);

    // start held during the done cycle is only taken the cycle after
    issue(32'h0000_5000, 32'h0000_1000);
    g = 0;
    while (!done && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done");
      summary_and_finish();
    end
    e = model(32'hFFFF_8000, 32'h0000_3000, cyc + 1);
    e.id = txn_id++;
    sb.push_back(e);
    in_1 = 32'hFFFF_8000; in_2 = 32'h0000_3000; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;

    // start mid-calculation must not disturb the running operation
    issue(32'h0003_0000, 32'h0000_7000);
    repeat (5) @(negedge clk);
    in_1 = 32'h0000_1234; in_2 = 32'h0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Randomised operands with a spread of magnitudes
    for (int i = 0; i < 25; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if ($urandom_range(0, 9) == 0) rb = 32'h0;
      issue(ra, rb);
    end

    // Reset in the middle of a calculation aborts without a done pulse
    issue(32'h0000_6000, 32'h0000_2000);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out", out, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    issue(32'h0000_1000, 32'h0000_3000);
    issue(32'hFFFF_D000, 32'hFFFF_E000);

    g = 0;
    while (sb.size() > 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d_pending required=0_pending", sb.size());
    end
    repeat (3) @(negedge clk);
    summary_and_finish();
  end

endmodule
